// File: rtl/ras_pkg.sv
// Shared constants, control-flow classification and RV32I link-hint decode
// for the return-address-stack controller.
package ras_pkg;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [4:0] LINK_X1  = 5'd1;
  localparam logic [4:0] LINK_X5  = 5'd5;

  typedef enum logic [1:0] {
    CF_NONE,
    CF_PUSH,
    CF_POP,
    CF_POPPUSH
  } cf_kind_t;

  function automatic logic is_link(input logic [4:0] rd);
    return (rd == LINK_X1) || (rd == LINK_X5);
  endfunction

  // JALR with both rd and rs1 as link registers is a coroutine swap only when
  // they differ; identical registers are treated as a plain call.
  function automatic cf_kind_t decode_cf(input logic [31:0] instr);
    logic [4:0] rd;
    logic [4:0] rs1;
    cf_kind_t   kind;
    rd   = instr[11:7];
    rs1  = instr[19:15];
    kind = CF_NONE;
    if (instr[6:0] == OPC_JAL) begin
      if (is_link(rd)) kind = CF_PUSH;
    end else if (instr[6:0] == OPC_JALR) begin
      case ({is_link(rd), is_link(rs1)})
        2'b10:   kind = CF_PUSH;
        2'b01:   kind = CF_POP;
        2'b11:   kind = (rd == rs1) ? CF_PUSH : CF_POPPUSH;
        default: kind = CF_NONE;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/ras_pred_queue.sv
// In-order FIFO of outstanding return predictions; clear dominates push/pop.
module ras_pred_queue #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: decodes call/return hints from fetch, drives
// the stack push/pop port and checks predicted returns against execute.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int DW   = 32,
  parameter int QDPT = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_fetch_valid,
  output logic            o_fetch_ready,
  input  logic [DW-1:0]   i_fetch_pc,
  input  logic [31:0]     i_fetch_instr,
  output logic            o_push_en,
  output logic [DW-1:0]   o_push_data,
  input  logic            i_full,
  output logic            o_pop_en,
  input  logic [DW-1:0]   i_pop_data,
  input  logic            i_empty,
  output logic            o_pred_valid,
  output logic [DW-1:0]   o_pred_target,
  input  logic            i_rslv_valid,
  input  logic [DW-1:0]   i_rslv_target,
  input  logic            i_flush,
  output logic            o_mispred,
  output logic [DW-1:0]   o_mispred_target,
  output logic [CNTW-1:0] o_hit_cnt,
  output logic [CNTW-1:0] o_miss_cnt
);

  cf_kind_t      kind;
  logic          acc;
  logic          q_full;
  logic          q_empty;
  logic [DW-1:0] q_head;
  logic          rslv_act;
  logic          hit;
  logic          miss;

  logic            pred_valid_q, pred_valid_d;
  logic [DW-1:0]   pred_target_q, pred_target_d;
  logic            mispred_q, mispred_d;
  logic [DW-1:0]   mispred_target_q, mispred_target_d;
  logic [CNTW-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNTW-1:0] miss_cnt_q, miss_cnt_d;

  // Stack overflow handling belongs to the stack itself; the flag is not needed here.
  logic unused_full;
  assign unused_full = i_full;

  assign kind          = decode_cf(i_fetch_instr);
  assign o_fetch_ready = ~q_full;
  assign acc           = i_fetch_valid & ~q_full & ~i_flush & ~rst;

  assign o_push_en   = acc & ((kind == CF_PUSH) | (kind == CF_POPPUSH));
  assign o_push_data = i_fetch_pc + DW'(4);
  assign o_pop_en    = acc & ((kind == CF_POP) | (kind == CF_POPPUSH)) & ~i_empty;

  // A flush discards any same-cycle resolve outright.
  assign rslv_act = i_rslv_valid & ~q_empty & ~i_flush & ~rst;
  assign hit      = rslv_act & (q_head == i_rslv_target);
  assign miss     = rslv_act & (q_head != i_rslv_target);

  ras_pred_queue #(
    .DW    (DW),
    .DEPTH (QDPT)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (o_pop_en),
    .push_data_i (i_pop_data),
    .pop_i       (rslv_act),
    .clear_i     (i_flush | miss),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .head_o      (q_head)
  );

  always_comb begin
    pred_valid_d     = o_pop_en;
    pred_target_d    = o_pop_en ? i_pop_data : pred_target_q;
    mispred_d        = miss;
    mispred_target_d = miss ? i_rslv_target : mispred_target_q;
    hit_cnt_d        = hit_cnt_q;
    miss_cnt_d       = miss_cnt_q;
    if (hit && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + CNTW'(1);
    if (miss && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q     <= 1'b0;
      pred_target_q    <= '0;
      mispred_q        <= 1'b0;
      mispred_target_q <= '0;
      hit_cnt_q        <= '0;
      miss_cnt_q       <= '0;
    end else begin
      pred_valid_q     <= pred_valid_d;
      pred_target_q    <= pred_target_d;
      mispred_q        <= mispred_d;
      mispred_target_q <= mispred_target_d;
      hit_cnt_q        <= hit_cnt_d;
      miss_cnt_q       <= miss_cnt_d;
    end
  end

  assign o_pred_valid     = pred_valid_q;
  assign o_pred_target    = pred_target_q;
  assign o_mispred        = mispred_q;
  assign o_mispred_target = mispred_target_q;
  assign o_hit_cnt        = hit_cnt_q;
  assign o_miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl; counters narrowed to 3 bits so saturation is reachable.
module tb_ras_ctrl;

  localparam int DW   = 32;
  localparam int QDPT = 4;
  localparam int CNTW = 3;

  logic            clk;
  logic            rst;
  logic            i_fetch_valid;
  logic            o_fetch_ready;
  logic [DW-1:0]   i_fetch_pc;
  logic [31:0]     i_fetch_instr;
  logic            o_push_en;
  logic [DW-1:0]   o_push_data;
  logic            i_full;
  logic            o_pop_en;
  logic [DW-1:0]   i_pop_data;
  logic            i_empty;
  logic            o_pred_valid;
  logic [DW-1:0]   o_pred_target;
  logic            i_rslv_valid;
  logic [DW-1:0]   i_rslv_target;
  logic            i_flush;
  logic            o_mispred;
  logic [DW-1:0]   o_mispred_target;
  logic [CNTW-1:0] o_hit_cnt;
  logic [CNTW-1:0] o_miss_cnt;

  int vectors = 0;
  int errors  = 0;

  ras_ctrl #(.DW(DW), .QDPT(QDPT), .CNTW(CNTW)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_fetch_valid    (i_fetch_valid),
    .o_fetch_ready    (o_fetch_ready),
    .i_fetch_pc       (i_fetch_pc),
    .i_fetch_instr    (i_fetch_instr),
    .o_push_en        (o_push_en),
    .o_push_data      (o_push_data),
    .i_full           (i_full),
    .o_pop_en         (o_pop_en),
    .i_pop_data       (i_pop_data),
    .i_empty          (i_empty),
    .o_pred_valid     (o_pred_valid),
    .o_pred_target    (o_pred_target),
    .i_rslv_valid     (i_rslv_valid),
    .i_rslv_target    (i_rslv_target),
    .i_flush          (i_flush),
    .o_mispred        (o_mispred),
    .o_mispred_target (o_mispred_target),
    .o_hit_cnt        (o_hit_cnt),
    .o_miss_cnt       (o_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_jal(input logic [4:0] rd);
    return {20'h0, rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h0, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_fetch_valid = 1'b0;
    i_fetch_pc    = '0;
    i_fetch_instr = '0;
    i_full        = 1'b0;
    i_pop_data    = '0;
    i_empty       = 1'b1;
    i_rslv_valid  = 1'b0;
    i_rslv_target = '0;
    i_flush       = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr,
                       input logic empty, input logic [31:0] top);
    i_fetch_valid = 1'b1;
    i_fetch_pc    = pc;
    i_fetch_instr = instr;
    i_empty       = empty;
    i_pop_data    = top;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    fetch(32'h40, enc_jal(5'd1), 1'b0, 32'h44);
    tick();
    tick();
    #1;
    vectors++; if (o_push_en !== 1'b0) begin errors++; $display("FAIL rst_push_en got %0b want 0", o_push_en); end
    vectors++; if (o_pop_en !== 1'b0) begin errors++; $display("FAIL rst_pop_en got %0b want 0", o_pop_en); end
    idle();
    #1;
    vectors++; if (o_fetch_ready !== 1'b1) begin errors++; $display("FAIL rst_fetch_ready got %0b want 1", o_fetch_ready); end
    vectors++; if (o_pred_valid !== 1'b0 || o_pred_target !== 32'h0) begin errors++; $display("FAIL rst_pred got %0b/%h want 0/0", o_pred_valid, o_pred_target); end
    vectors++; if (o_mispred !== 1'b0 || o_mispred_target !== 32'h0) begin errors++; $display("FAIL rst_mispred got %0b/%h want 0/0", o_mispred, o_mispred_target); end
    vectors++; if (o_hit_cnt !== 3'd0 || o_miss_cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", o_hit_cnt, o_miss_cnt); end
    $display("reset: applied");
    rst = 1'b0;
    tick();
  endtask

  task automatic test_jal_push();
    fetch(32'h0000_1000, enc_jal(5'd1), 1'b1, 32'h0);
    #1;
    vectors++; if (o_push_en !== 1'b1 || o_pop_en !== 1'b0) begin errors++; $display("FAIL jal_x1_en got push=%0b pop=%0b want 1/0", o_push_en, o_pop_en); end
    vectors++; if (o_push_data !== 32'h0000_1004) begin errors++; $display("FAIL jal_x1_data got %h want 00001004", o_push_data); end
    tick();
    vectors++; if (o_pred_valid !== 1'b0) begin errors++; $display("FAIL jal_no_pred got %0b want 0", o_pred_valid); end
    fetch(32'h0000_2000, enc_jal(5'd0), 1'b1, 32'h0);
    #1;
    vectors++; if (o_push_en !== 1'b0) begin errors++; $display("FAIL jal_x0_push got %0b want 0", o_push_en); end
    fetch(32'hFFFF_FFFC, enc_jal(5'd5), 1'b1, 32'h0);
    #1;
    vectors++; if (o_push_en !== 1'b1 || o_push_data !== 32'h0) begin errors++; $display("FAIL jal_x5_wrap got %0b/%h want 1/00000000", o_push_en, o_push_data); end
    $display("jal push: pc+4 = %h", o_push_data);
    idle();
    tick();
  endtask

  task automatic test_return_hit();
    fetch(32'h0000_1800, enc_jalr(5'd0, 5'd1), 1'b0, 32'h0000_1004);
    #1;
    vectors++; if (o_pop_en !== 1'b1 || o_push_en !== 1'b0) begin errors++; $display("FAIL ret_en got pop=%0b push=%0b want 1/0", o_pop_en, o_push_en); end
    tick();
    idle();
    vectors++; if (o_pred_valid !== 1'b1 || o_pred_target !== 32'h0000_1004) begin errors++; $display("FAIL ret_pred got %0b/%h want 1/00001004", o_pred_valid, o_pred_target); end
    i_rslv_valid = 1'b1; i_rslv_target = 32'h0000_1004;
    tick();
    i_rslv_valid = 1'b0;
    vectors++; if (o_pred_valid !== 1'b0) begin errors++; $display("FAIL ret_pred_pulse got %0b want 0", o_pred_valid); end
    vectors++; if (o_hit_cnt !== 3'd1 || o_miss_cnt !== 3'd0 || o_mispred !== 1'b0) begin errors++; $display("FAIL ret_hit got hit=%0d miss=%0d mp=%0b want 1/0/0", o_hit_cnt, o_miss_cnt, o_mispred); end
    $display("return hit: hit_cnt=%0d", o_hit_cnt);
  endtask

  task automatic test_empty_return();
    fetch(32'h0000_1900, enc_jalr(5'd0, 5'd1), 1'b1, 32'hDEAD_0000);
    #1;
    vectors++; if (o_pop_en !== 1'b0 || o_push_en !== 1'b0) begin errors++; $display("FAIL empty_ret_en got pop=%0b push=%0b want 0/0", o_pop_en, o_push_en); end
    tick();
    idle();
    vectors++; if (o_pred_valid !== 1'b0) begin errors++; $display("FAIL empty_ret_pred got %0b want 0", o_pred_valid); end
    i_rslv_valid = 1'b1; i_rslv_target = 32'hDEAD_0000;
    tick();
    i_rslv_valid = 1'b0;
    vectors++; if (o_hit_cnt !== 3'd1 || o_miss_cnt !== 3'd0 || o_mispred !== 1'b0) begin errors++; $display("FAIL empty_rslv got hit=%0d miss=%0d mp=%0b want 1/0/0", o_hit_cnt, o_miss_cnt, o_mispred); end
    $display("empty return: ignored");
  endtask

  task automatic test_poppush();
    fetch(32'h200, enc_jalr(5'd1, 5'd5), 1'b0, 32'h500);
    #1;
    vectors++; if (o_push_en !== 1'b1 || o_pop_en !== 1'b1 || o_push_data !== 32'h204) begin errors++; $display("FAIL pp_en got push=%0b pop=%0b data=%h want 1/1/204", o_push_en, o_pop_en, o_push_data); end
    tick();
    idle();
    vectors++; if (o_pred_valid !== 1'b1 || o_pred_target !== 32'h500) begin errors++; $display("FAIL pp_pred got %0b/%h want 1/500", o_pred_valid, o_pred_target); end
    fetch(32'h300, enc_jalr(5'd5, 5'd1), 1'b1, 32'h0);
    #1;
    vectors++; if (o_push_en !== 1'b1 || o_pop_en !== 1'b0) begin errors++; $display("FAIL pp_empty got push=%0b pop=%0b want 1/0", o_push_en, o_pop_en); end
    fetch(32'h400, enc_jalr(5'd1, 5'd1), 1'b0, 32'h600);
    #1;
    vectors++; if (o_push_en !== 1'b1 || o_pop_en !== 1'b0) begin errors++; $display("FAIL same_link got push=%0b pop=%0b want 1/0", o_push_en, o_pop_en); end
    idle();
    i_rslv_valid = 1'b1; i_rslv_target = 32'h500;
    tick();
    i_rslv_valid = 1'b0;
    vectors++; if (o_hit_cnt !== 3'd2 || o_miss_cnt !== 3'd0) begin errors++; $display("FAIL pp_rslv got hit=%0d miss=%0d want 2/0", o_hit_cnt, o_miss_cnt); end
    $display("poppush: push %h pred %h", 32'h204, 32'h500);
  endtask

  task automatic test_queue_full();
    for (int k = 1; k <= 4; k++) begin
      fetch(32'h800 + 32'(k) * 32'h10, enc_jalr(5'd0, 5'd1), 1'b0, 32'(k) * 32'h10);
      tick();
    end
    fetch(32'h900, enc_jal(5'd1), 1'b0, 32'h50);
    #1;
    vectors++; if (o_fetch_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", o_fetch_ready); end
    vectors++; if (o_push_en !== 1'b0) begin errors++; $display("FAIL full_push_blocked got %0b want 0", o_push_en); end
    idle();
    i_rslv_valid = 1'b1; i_rslv_target = 32'h10;
    tick();
    vectors++; if (o_hit_cnt !== 3'd3 || o_fetch_ready !== 1'b1) begin errors++; $display("FAIL full_hit got hit=%0d ready=%0b want 3/1", o_hit_cnt, o_fetch_ready); end
    i_rslv_target = 32'h99;
    fetch(32'hA00, enc_jalr(5'd0, 5'd1), 1'b0, 32'h77);
    tick();
    idle();
    vectors++; if (o_miss_cnt !== 3'd1 || o_hit_cnt !== 3'd3) begin errors++; $display("FAIL full_miss_cnt got hit=%0d miss=%0d want 3/1", o_hit_cnt, o_miss_cnt); end
    vectors++; if (o_mispred !== 1'b1 || o_mispred_target !== 32'h99) begin errors++; $display("FAIL full_mispred got %0b/%h want 1/99", o_mispred, o_mispred_target); end
    vectors++; if (o_fetch_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after got %0b want 1", o_fetch_ready); end
    tick();
    vectors++; if (o_mispred !== 1'b0) begin errors++; $display("FAIL mispred_pulse got %0b want 0", o_mispred); end
    i_rslv_valid = 1'b1; i_rslv_target = 32'h77;
    tick();
    i_rslv_valid = 1'b0;
    vectors++; if (o_hit_cnt !== 3'd3 || o_miss_cnt !== 3'd1) begin errors++; $display("FAIL cleared_q got hit=%0d miss=%0d want 3/1", o_hit_cnt, o_miss_cnt); end
    $display("queue full: hit=%0d miss=%0d", o_hit_cnt, o_miss_cnt);
  endtask

  task automatic test_back_to_back();
    fetch(32'hB00, enc_jalr(5'd0, 5'd5), 1'b0, 32'hA0);
    tick();
    fetch(32'hB10, enc_jalr(5'd0, 5'd5), 1'b0, 32'hB0);
    i_rslv_valid = 1'b1; i_rslv_target = 32'hA0;
    tick();
    idle();
    vectors++; if (o_hit_cnt !== 3'd4 || o_pred_valid !== 1'b1 || o_pred_target !== 32'hB0) begin errors++; $display("FAIL b2b_first got hit=%0d pv=%0b tgt=%h want 4/1/b0", o_hit_cnt, o_pred_valid, o_pred_target); end
    i_rslv_valid = 1'b1; i_rslv_target = 32'hB0;
    tick();
    i_rslv_valid = 1'b0;
    vectors++; if (o_hit_cnt !== 3'd5 || o_miss_cnt !== 3'd1) begin errors++; $display("FAIL b2b_second got hit=%0d miss=%0d want 5/1", o_hit_cnt, o_miss_cnt); end
    $display("back to back: hit=%0d", o_hit_cnt);
  endtask

  task automatic test_flush();
    fetch(32'hC00, enc_jalr(5'd0, 5'd1), 1'b0, 32'h70);
    tick();
    fetch(32'hC10, enc_jal(5'd1), 1'b0, 32'h0);
    i_flush = 1'b1;
    i_rslv_valid = 1'b1; i_rslv_target = 32'h71;
    #1;
    vectors++; if (o_push_en !== 1'b0) begin errors++; $display("FAIL flush_block got %0b want 0", o_push_en); end
    tick();
    idle();
    vectors++; if (o_mispred !== 1'b0 || o_hit_cnt !== 3'd5 || o_miss_cnt !== 3'd1) begin errors++; $display("FAIL flush_rslv got mp=%0b hit=%0d miss=%0d want 0/5/1", o_mispred, o_hit_cnt, o_miss_cnt); end
    i_rslv_valid = 1'b1; i_rslv_target = 32'h70;
    tick();
    i_rslv_valid = 1'b0;
    vectors++; if (o_hit_cnt !== 3'd5) begin errors++; $display("FAIL flush_clear got hit=%0d want 5", o_hit_cnt); end
    $display("flush: queue dropped");
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 3; k++) begin
      fetch(32'hD00, enc_jalr(5'd0, 5'd1), 1'b0, 32'h100 + 32'(k));
      tick();
      idle();
      i_rslv_valid = 1'b1; i_rslv_target = 32'h100 + 32'(k);
      tick();
      i_rslv_valid = 1'b0;
    end
    vectors++; if (o_hit_cnt !== 3'd7) begin errors++; $display("FAIL hit_sat got %0d want 7", o_hit_cnt); end
    for (int k = 0; k < 7; k++) begin
      fetch(32'hE00, enc_jalr(5'd0, 5'd1), 1'b0, 32'h200);
      tick();
      idle();
      i_rslv_valid = 1'b1; i_rslv_target = 32'h201;
      tick();
      i_rslv_valid = 1'b0;
    end
    vectors++; if (o_miss_cnt !== 3'd7 || o_hit_cnt !== 3'd7) begin errors++; $display("FAIL miss_sat got hit=%0d miss=%0d want 7/7", o_hit_cnt, o_miss_cnt); end
    $display("saturate: hit=%0d miss=%0d", o_hit_cnt, o_miss_cnt);
  endtask

  task automatic test_reset_mid();
    fetch(32'hF00, enc_jalr(5'd0, 5'd1), 1'b0, 32'h55);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (o_hit_cnt !== 3'd0 || o_miss_cnt !== 3'd0 || o_pred_valid !== 1'b0) begin errors++; $display("FAIL mid_rst got hit=%0d miss=%0d pv=%0b want 0/0/0", o_hit_cnt, o_miss_cnt, o_pred_valid); end
    i_rslv_valid = 1'b1; i_rslv_target = 32'h55;
    tick();
    i_rslv_valid = 1'b0;
    vectors++; if (o_hit_cnt !== 3'd0 || o_fetch_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_q got hit=%0d ready=%0b want 0/1", o_hit_cnt, o_fetch_ready); end
    $display("mid reset: cleared");
  endtask

  initial begin
    test_reset();
    test_jal_push();
    test_return_hit();
    test_empty_return();
    test_poppush();
    test_queue_full();
    test_back_to_back();
    test_flush();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
Return-address-stack controller; drives the push/pop side of the call stack from the fetch stream.
- Decodes RV32I JAL/JALR link hints and pushes PC+4 on calls.
- Pops on returns and issues the popped address as the predicted return target.
- Tracks outstanding predictions in a small in-order queue and checks them against resolved targets from execute, flagging mispredicts and keeping hit/miss statistics.

Parameters:
DW, 32, PC / return-address width; matches the call stack data width.
QDPT, 4, pending-prediction queue depth; must be a power of 2.
CNTW, 16, width of the hit/miss statistics counters.

Ports:
clk  in  1  Clock
rst  in  1  Reset; synchronous, active-high
i_fetch_valid  in  1  Fetched instruction valid
o_fetch_ready  out  1  Controller accepts instruction; = !queue_full
i_fetch_pc  in  DW  PC of fetched instruction
i_fetch_instr  in  32  Fetched instruction word
o_push_en  out  1  To stack push enable
o_push_data  out  DW  To stack push data (PC+4)
i_full  in  1  Stack full flag (informational only; push is never blocked)
o_pop_en  out  1  To stack pop enable
i_pop_data  in  DW  Stack top data, combinational from stack
i_empty  in  1  Stack empty flag
o_pred_valid  out  1  Registered one-cycle pulse: return predicted
o_pred_target  out  DW  Predicted return target
i_rslv_valid  in  1  Execute resolves the oldest predicted return
i_rslv_target  in  DW  Actual return target
i_flush  in  1  Pipeline flush; drops all pending predictions
o_mispred  out  1  Registered one-cycle pulse: mispredict detected
o_mispred_target  out  DW  Correct target on mispredict
o_hit_cnt  out  CNTW  Saturating count of correct predictions
o_miss_cnt  out  CNTW  Saturating count of mispredictions

Behaviour:
- Reset: all outputs 0, except o_fetch_ready = 1; queue empty; counters 0.
- Accept: acc = i_fetch_valid & o_fetch_ready & !i_flush. The stack port outputs are combinational from acc and decode.
- Decode: link = x1 or x5.
  - JAL (opcode 1101111): if rd is link, PUSH.
  - JALR (opcode 1100111):
    - rd link, rs1 not link: PUSH.
    - rd not link, rs1 link: POP.
    - both link, rd != rs1: POPPUSH.
    - both link, rd == rs1: PUSH.
  - All else: NONE.
- PUSH: o_push_en = 1; o_push_data = i_fetch_pc + 4, wrapping modulo 2^DW.
- POP:
  - If !i_empty: o_pop_en = 1; capture i_pop_data into o_pred_target; o_pred_valid = 1 next cycle; enqueue the target.
  - If i_empty: no pop, no prediction, no enqueue.
- POPPUSH: o_push_en and o_pop_en both asserted in the same cycle (the stack overwrites its top). Prediction and enqueue follow the POP rule; if i_empty, push only.
- Queue: FIFO of QDPT entries in program order.
  - o_fetch_ready = 0 while full, for any instruction type.
  - Enqueue and dequeue in the same cycle are both honoured; occupancy is unchanged.
- Resolve: with i_rslv_valid and a non-empty queue, dequeue the head.
  - Equal to i_rslv_target: o_hit_cnt++.
  - Not equal: o_miss_cnt++; o_mispred = 1 next cycle; o_mispred_target = i_rslv_target; the whole queue is cleared, including any same-cycle enqueue.
  - i_rslv_valid with an empty queue is ignored.
- Counters saturate at all-ones; no wrap.
- i_flush:
  - Clears the queue next cycle and blocks acceptance that cycle.
  - A same-cycle resolve is dropped: no counter update, no o_mispred.
  - Stack contents are untouched.
- Stack full: push still issued; the stack drops its oldest entry.
- rst asserted mid-operation: the queue, pulses and counters clear at the next clock edge; the stack is reset separately by its owner.

Decomposition:
- Package ras_pkg:
  - OPC_JAL, OPC_JALR constants.
  - LINK_X1, LINK_X5 constants.
  - typedef enum cf_kind_t {CF_NONE, CF_PUSH, CF_POP, CF_POPPUSH}.
  - function is_link(rd).
- Sub-module ras_pred_queue: synchronous FIFO with push/pop/clear, full/empty flags and a head output.

Test Plan:
1. JAL x1 at PC 0x0000_1000 -> o_push_en = 1, o_push_data = 0x0000_1004; no o_pred_valid.
2. Return JALR x0,0(x1) after (1) -> o_pop_en = 1; next cycle o_pred_valid = 1, o_pred_target = 0x0000_1004; resolve with 0x0000_1004 -> o_hit_cnt = 1, no o_mispred.
3. Return with stack i_empty = 1 -> o_pop_en = 0, o_pred_valid = 0, queue unchanged; resolve with queue empty -> ignored, counters unchanged.
4. JALR x1,0(x5) at PC 0x200 with stack top 0x500 -> push and pop in the same cycle, o_push_data = 0x204, o_pred_target = 0x500.
5. Four returns predicted 0x10, 0x20, 0x30, 0x40 -> o_fetch_ready = 0; resolve 0x10 then 0x99 -> o_hit_cnt = 1, o_miss_cnt = 1, o_mispred pulse with target 0x99, queue empty, o_fetch_ready = 1.
6. i_flush coincident with i_rslv_valid carrying a wrong target -> no o_mispred, counters unchanged, queue empty next cycle.
